line_steer_pwm: RTL and testbench

- Downstream stage of line_follow_display, in the 50 MHz domain.
- Once per camera frame it consumes the signed steering error, the detected flag and the half-break flag, and runs a PD correction through a lost-line state machine.
- It produces glitch-free left/right motor PWM for the robot drive.

---
 rtl/line_steer_pwm.sv | 187 ++++++++++++++++++
 tb/tb_line_steer_pwm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/line_steer_pwm.sv
// Per-frame PD steering with lost-line recovery, driving two shadow-buffered motor PWMs.
// Latency: targets/update_pulse 2 clk after frame_pulse; active duties follow at the next counter wrap.
module line_steer_pwm #(
    parameter int PWM_BITS      = 10,
    parameter int BASE_DUTY     = 512,
    parameter int KP            = 4,
    parameter int KD            = 2,
    parameter int SHIFT         = 3,
    parameter int LOST_FRAMES   = 8,
    parameter int SEARCH_FRAMES = 60,
    parameter int SEARCH_DUTY   = 300
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                frame_pulse,
    input  logic [15:0]         error,
    input  logic                detected,
    input  logic                half_break,
    output logic [PWM_BITS-1:0] duty_left,
    output logic [PWM_BITS-1:0] duty_right,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic [1:0]          state,
    output logic                stopped,
    output logic                update_pulse
);
    typedef enum logic [2:0] {S_IDLE, S_TRACK, S_COAST, S_SEARCH, S_STOP} st_e;
    typedef enum logic [1:0] {M_CALC, M_SPIN_POS, M_SPIN_NEG, M_ZERO} mode_e;

    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] SEARCH_D   = PWM_BITS'(SEARCH_DUTY);
    localparam logic signed [23:0]  KP_S       = 24'(KP);
    localparam logic signed [23:0]  KD_S       = 24'(KD);
    localparam logic signed [23:0]  BASE_FULL  = 24'(BASE_DUTY);
    localparam logic signed [23:0]  BASE_HALF  = 24'(BASE_DUTY >> 1);
    localparam logic signed [23:0]  DUTY_MAX_S = 24'((1 << PWM_BITS) - 1);
    localparam logic [6:0]          LOST_C     = 7'(LOST_FRAMES);
    localparam logic [6:0]          SEARCH_C   = 7'(SEARCH_FRAMES);

    st_e                  st_q, st_d;
    logic [6:0]           lost_q, lost_d, lost_inc;
    logic signed [15:0]   prev_q, prev_d, prev_eff;
    logic signed [16:0]   diff;
    logic signed [23:0]   err_x, diff_x, sum_c;
    logic                 s1_vld_q, s1_vld_d, s1_half_q;
    mode_e                s1_mode_q, s1_mode_d;
    logic signed [23:0]   s1_sum_q, corr, base, left_raw, right_raw;
    logic [PWM_BITS-1:0]  tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic                 upd_q, upd_d;
    logic [PWM_BITS-1:0]  cnt_q, cnt_d, duty_l_q, duty_l_d, duty_r_q, duty_r_d;
    logic                 pwm_l_q, pwm_r_q;

    function automatic logic [PWM_BITS-1:0] clamp(input logic signed [23:0] v);
        if (v < 0)               return '0;
        else if (v > DUTY_MAX_S) return CNT_MAX;
        else                     return v[PWM_BITS-1:0];
    endfunction

    // Re-entering TRACK seeds the derivative history with the current error so d = 0.
    assign prev_eff = (st_q == S_TRACK) ? prev_q : error;
    assign diff     = {error[15], error} - {prev_eff[15], prev_eff};
    assign err_x    = {{8{error[15]}}, error};
    assign diff_x   = {{7{diff[16]}}, diff};
    assign sum_c    = KP_S * err_x + KD_S * diff_x;
    assign lost_inc = lost_q + 7'd1;

    always_comb begin
        st_d      = st_q;
        lost_d    = lost_q;
        prev_d    = prev_q;
        s1_vld_d  = 1'b0;
        s1_mode_d = M_CALC;
        if (!enable) begin
            st_d   = S_IDLE;
            lost_d = '0;
        end else if (frame_pulse) begin
            if (detected) begin
                st_d     = S_TRACK;
                lost_d   = '0;
                prev_d   = error;
                s1_vld_d = 1'b1;
            end else begin
                case (st_q)
                    S_TRACK: begin
                        st_d   = S_COAST;
                        lost_d = 7'd1;
                    end
                    S_COAST: begin
                        lost_d = lost_inc;
                        if (lost_inc == LOST_C) begin
                            st_d      = S_SEARCH;
                            lost_d    = '0;
                            s1_vld_d  = 1'b1;
                            s1_mode_d = prev_q[15] ? M_SPIN_NEG : M_SPIN_POS;
                        end
                    end
                    S_SEARCH: begin
                        lost_d = lost_inc;
                        if (lost_inc == SEARCH_C) begin
                            st_d      = S_STOP;
                            s1_vld_d  = 1'b1;
                            s1_mode_d = M_ZERO;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign corr      = s1_sum_q >>> SHIFT;
    assign base      = s1_half_q ? BASE_HALF : BASE_FULL;
    assign left_raw  = base + corr;
    assign right_raw = base - corr;

    always_comb begin
        tgt_l_d = tgt_l_q;
        tgt_r_d = tgt_r_q;
        upd_d   = 1'b0;
        if (!enable) begin
            tgt_l_d = '0;
            tgt_r_d = '0;
        end else if (s1_vld_q) begin
            upd_d = 1'b1;
            case (s1_mode_q)
                M_CALC:     begin tgt_l_d = clamp(left_raw); tgt_r_d = clamp(right_raw); end
                M_SPIN_POS: begin tgt_l_d = SEARCH_D;        tgt_r_d = '0;               end
                M_SPIN_NEG: begin tgt_l_d = '0;              tgt_r_d = SEARCH_D;         end
                default:    begin tgt_l_d = '0;              tgt_r_d = '0;               end
            endcase
        end
    end

    // Shadow targets reach the active duty only at the wrap, so a period is never cut short.
    always_comb begin
        cnt_d    = cnt_q + PWM_BITS'(1);
        duty_l_d = (cnt_q == CNT_MAX) ? tgt_l_q : duty_l_q;
        duty_r_d = (cnt_q == CNT_MAX) ? tgt_r_q : duty_r_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q      <= S_IDLE;
            lost_q    <= '0;
            prev_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_mode_q <= M_CALC;
            s1_sum_q  <= '0;
            s1_half_q <= 1'b0;
            tgt_l_q   <= '0;
            tgt_r_q   <= '0;
            upd_q     <= 1'b0;
            cnt_q     <= '0;
            duty_l_q  <= '0;
            duty_r_q  <= '0;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
        end else begin
            st_q      <= st_d;
            lost_q    <= lost_d;
            prev_q    <= prev_d;
            s1_vld_q  <= s1_vld_d;
            s1_mode_q <= s1_mode_d;
            s1_sum_q  <= sum_c;
            s1_half_q <= half_break;
            tgt_l_q   <= tgt_l_d;
            tgt_r_q   <= tgt_r_d;
            upd_q     <= upd_d;
            cnt_q     <= cnt_d;
            duty_l_q  <= duty_l_d;
            duty_r_q  <= duty_r_d;
            pwm_l_q   <= (cnt_d < duty_l_d);
            pwm_r_q   <= (cnt_d < duty_r_d);
        end
    end

    assign duty_left    = duty_l_q;
    assign duty_right   = duty_r_q;
    assign pwm_left     = pwm_l_q;
    assign pwm_right    = pwm_r_q;
    assign update_pulse = upd_q;
    assign stopped      = (st_q == S_STOP);
    assign state        = (st_q == S_IDLE)  ? 2'd0 :
                          (st_q == S_TRACK) ? 2'd1 :
                          (st_q == S_COAST) ? 2'd2 : 2'd3;
endmodule

// File: tb/tb_line_steer_pwm.sv
// Directed bench for line_steer_pwm: PD math, clamping, shadow duty timing, lost-line FSM, enable and reset.
module tb_line_steer_pwm;
    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              frame_pulse;
    logic signed [15:0] error;
    logic              detected;
    logic              half_break;
    logic [9:0]        duty_left, duty_right;
    logic              pwm_left, pwm_right;
    logic [1:0]        state;
    logic              stopped, update_pulse;

    int ntests = 0;
    int nfail  = 0;
    logic [9:0] mcnt;

    line_steer_pwm dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_pulse(frame_pulse),
        .error(error), .detected(detected), .half_break(half_break),
        .duty_left(duty_left), .duty_right(duty_right),
        .pwm_left(pwm_left), .pwm_right(pwm_right),
        .state(state), .stopped(stopped), .update_pulse(update_pulse)
    );

    always #10 clk = ~clk;

    // Reference free-running counter, used to locate period boundaries.
    always @(posedge clk) begin
        if (!reset_n) mcnt <= '0;
        else          mcnt <= mcnt + 10'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrap();
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (mcnt == 10'd0) break;
        end
    endtask

    task automatic send_frame(input int e, input logic det, input logic hb);
        tick();
        frame_pulse = 1'b1;
        error       = 16'(e);
        detected    = det;
        half_break  = hb;
        tick();
        frame_pulse = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; frame_pulse = 1'b0;
        error = '0; detected = 1'b0; half_break = 1'b0;
        repeat (3) tick();
        ntests++; if (duty_left !== 10'd0)  begin nfail++; $display("FAIL reset_duty_left: got %0d expected 0", duty_left); end
        ntests++; if (duty_right !== 10'd0) begin nfail++; $display("FAIL reset_duty_right: got %0d expected 0", duty_right); end
        ntests++; if ({pwm_left, pwm_right} !== 2'b00) begin nfail++; $display("FAIL reset_pwm: got %b expected 00", {pwm_left, pwm_right}); end
        ntests++; if (state !== 2'd0) begin nfail++; $display("FAIL reset_state: got %0d expected 0", state); end
        ntests++; if ({stopped, update_pulse} !== 2'b00) begin nfail++; $display("FAIL reset_flags: got %b expected 00", {stopped, update_pulse}); end
        reset_n = 1'b1;
    endtask

    task automatic test_track_first();
        enable = 1'b1;
        wait_wrap();
        repeat (100) tick();
        send_frame(40, 1'b1, 1'b0);
        ntests++; if (state !== 2'd1) begin nfail++; $display("FAIL track_state: got %0d expected 1", state); end
        ntests++; if (update_pulse !== 1'b0) begin nfail++; $display("FAIL track_upd_early: got %b expected 0", update_pulse); end
        tick();
        ntests++; if (update_pulse !== 1'b1) begin nfail++; $display("FAIL track_upd: got %b expected 1", update_pulse); end
        ntests++; if (duty_left !== 10'd0) begin nfail++; $display("FAIL track_midperiod: got %0d expected 0", duty_left); end
        tick();
        ntests++; if (update_pulse !== 1'b0) begin nfail++; $display("FAIL track_upd_oneshot: got %b expected 0", update_pulse); end
        wait_wrap();
        ntests++; if (duty_left !== 10'd532)  begin nfail++; $display("FAIL track_left: got %0d expected 532", duty_left); end
        ntests++; if (duty_right !== 10'd492) begin nfail++; $display("FAIL track_right: got %0d expected 492", duty_right); end
    endtask

    task automatic test_derivative();
        send_frame(40, 1'b1, 1'b0);
        repeat (3) tick();
        send_frame(-80, 1'b1, 1'b0);
        repeat (3) tick();
        wait_wrap();
        ntests++; if (duty_left !== 10'd442)  begin nfail++; $display("FAIL deriv_left: got %0d expected 442", duty_left); end
        ntests++; if (duty_right !== 10'd582) begin nfail++; $display("FAIL deriv_right: got %0d expected 582", duty_right); end
    endtask

    task automatic test_clamp();
        send_frame(2000, 1'b1, 1'b0);
        repeat (3) tick();
        wait_wrap();
        ntests++; if (duty_left !== 10'd1023) begin nfail++; $display("FAIL clamp_left: got %0d expected 1023", duty_left); end
        ntests++; if (duty_right !== 10'd0)   begin nfail++; $display("FAIL clamp_right: got %0d expected 0", duty_right); end
    endtask

    task automatic test_half_break();
        int hl = 0;
        int hr = 0;
        send_frame(0, 1'b1, 1'b0);
        repeat (3) tick();
        wait_wrap();
        ntests++; if (duty_right !== 10'd1012) begin nfail++; $display("FAIL zero_after_big_right: got %0d expected 1012", duty_right); end
        send_frame(0, 1'b1, 1'b1);
        repeat (3) tick();
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd256, 10'd256}) begin nfail++; $display("FAIL half_duties: got %0d/%0d expected 256/256", duty_left, duty_right); end
        for (int i = 0; i < 1024; i++) begin
            if (pwm_left)  hl++;
            if (pwm_right) hr++;
            tick();
        end
        ntests++; if (hl != 256) begin nfail++; $display("FAIL half_pwm_left_high: got %0d expected 256", hl); end
        ntests++; if (hr != 256) begin nfail++; $display("FAIL half_pwm_right_high: got %0d expected 256", hr); end
    endtask

    task automatic test_lost_line();
        send_frame(40, 1'b1, 1'b0);
        repeat (3) tick();
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd542, 10'd482}) begin nfail++; $display("FAIL lost_pre: got %0d/%0d expected 542/482", duty_left, duty_right); end
        for (int i = 0; i < 7; i++) begin send_frame(0, 1'b0, 1'b0); repeat (3) tick(); end
        ntests++; if (state !== 2'd2) begin nfail++; $display("FAIL coast_state: got %0d expected 2", state); end
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd542, 10'd482}) begin nfail++; $display("FAIL coast_hold: got %0d/%0d expected 542/482", duty_left, duty_right); end
        send_frame(0, 1'b0, 1'b0);
        ntests++; if (state !== 2'd3) begin nfail++; $display("FAIL search_state: got %0d expected 3", state); end
        tick();
        ntests++; if (update_pulse !== 1'b1) begin nfail++; $display("FAIL search_upd: got %b expected 1", update_pulse); end
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd300, 10'd0}) begin nfail++; $display("FAIL search_duties: got %0d/%0d expected 300/0", duty_left, duty_right); end
        for (int i = 0; i < 59; i++) begin send_frame(0, 1'b0, 1'b0); repeat (3) tick(); end
        ntests++; if ({state, stopped} !== {2'd3, 1'b0}) begin nfail++; $display("FAIL search_59: got state %0d stopped %b expected 3/0", state, stopped); end
        send_frame(0, 1'b0, 1'b0);
        ntests++; if ({state, stopped} !== {2'd3, 1'b1}) begin nfail++; $display("FAIL stop_state: got state %0d stopped %b expected 3/1", state, stopped); end
        repeat (3) tick();
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== 20'd0) begin nfail++; $display("FAIL stop_duties: got %0d/%0d expected 0/0", duty_left, duty_right); end
        send_frame(10, 1'b1, 1'b0);
        ntests++; if ({state, stopped} !== {2'd1, 1'b0}) begin nfail++; $display("FAIL recover_state: got state %0d stopped %b expected 1/0", state, stopped); end
        repeat (3) tick();
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd517, 10'd507}) begin nfail++; $display("FAIL recover_duties: got %0d/%0d expected 517/507", duty_left, duty_right); end
    endtask

    task automatic test_enable_drop();
        logic saw_upd = 1'b0;
        wait_wrap();
        repeat (200) tick();
        enable = 1'b0;
        tick();
        ntests++; if (state !== 2'd0) begin nfail++; $display("FAIL endrop_state: got %0d expected 0", state); end
        ntests++; if (duty_left !== 10'd517) begin nfail++; $display("FAIL endrop_midperiod: got %0d expected 517", duty_left); end
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== 20'd0) begin nfail++; $display("FAIL endrop_duties: got %0d/%0d expected 0/0", duty_left, duty_right); end
        enable = 1'b1;
        send_frame(10, 1'b1, 1'b0);
        repeat (3) tick();
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd517, 10'd507}) begin nfail++; $display("FAIL reenable_duties: got %0d/%0d expected 517/507", duty_left, duty_right); end
        repeat (50) tick();
        frame_pulse = 1'b1; enable = 1'b0; error = 16'(500); detected = 1'b1;
        tick();
        frame_pulse = 1'b0;
        ntests++; if (state !== 2'd0) begin nfail++; $display("FAIL same_cycle_state: got %0d expected 0", state); end
        for (int i = 0; i < 3; i++) begin
            if (update_pulse) saw_upd = 1'b1;
            tick();
        end
        ntests++; if (saw_upd !== 1'b0) begin nfail++; $display("FAIL same_cycle_upd: got %b expected 0", saw_upd); end
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== 20'd0) begin nfail++; $display("FAIL same_cycle_duties: got %0d/%0d expected 0/0", duty_left, duty_right); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_search();
        send_frame(40, 1'b1, 1'b0);
        repeat (3) tick();
        wait_wrap();
        ntests++; if ({duty_left, duty_right} !== {10'd532, 10'd492}) begin nfail++; $display("FAIL idle_entry_duties: got %0d/%0d expected 532/492", duty_left, duty_right); end
        for (int i = 0; i < 8; i++) begin send_frame(0, 1'b0, 1'b0); repeat (3) tick(); end
        wait_wrap();
        repeat (50) tick();
        ntests++; if ({state, duty_left} !== {2'd3, 10'd300}) begin nfail++; $display("FAIL presreset_search: got state %0d left %0d expected 3/300", state, duty_left); end
        reset_n = 1'b0;
        tick();
        ntests++; if ({duty_left, duty_right} !== 20'd0) begin nfail++; $display("FAIL rst_mid_duties: got %0d/%0d expected 0/0", duty_left, duty_right); end
        ntests++; if ({pwm_left, pwm_right, stopped, update_pulse} !== 4'b0000) begin nfail++; $display("FAIL rst_mid_bits: got %b expected 0000", {pwm_left, pwm_right, stopped, update_pulse}); end
        ntests++; if (state !== 2'd0) begin nfail++; $display("FAIL rst_mid_state: got %0d expected 0", state); end
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_track_first();
        test_derivative();
        test_clamp();
        test_half_break();
        test_lost_line();
        test_enable_drop();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
